ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered instruction decoder with a one-entry output buffer
//
// Purpose:
//   Accepts instructions {opcode[4], rd, rs1, rs2} through a valid/ready
//   handshake. It decodes each one into a one-hot ALU operation, an operand
//   source select and a register-write flag. The result is held in a single
//   output entry until the downstream stage takes it. Opcode 0 (nop) is
//   accepted and then dropped. Two counters track retired entries and
//   hazard-stall cycles.
//
// Configuration:
//   CTRL_PIPE_HAZARD_EN - when defined, the block detects read-after-write
//   hazards against the held entry and the entry that just left, and counts
//   stall cycles. When it is undefined, hazard is always 0 and stall_cnt
//   stays at 0.
//
// Parameters:
//   REG_AW  register-address field width (instruction width = 4 + 3*REG_AW)
//   CNT_W   width of retired_cnt and stall_cnt
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     instruction offered on inst
//   in_ready     block accepts inst this cycle
//   inst         opcode, rd, rs1, rs2 (MSB first)
//   out_valid    held decoded entry is valid
//   out_ready    downstream consumes the entry this cycle
//   alu_op       one-hot ALU operation of the held entry
//   alu_src      0 = reg[rs2], 1 = rs2 field used as immediate
//   reg_write    held entry writes register rd
//   rd/rs1/rs2   register fields of the held entry
//   retired_cnt  output handshakes, wrapping
//   stall_cnt    hazard-stall cycles, saturating

module ctrl_pipe #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16,
  localparam int INST_W = 4 + 3 * REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [12:0]       alu_op,
  output logic              alu_src,
  output logic              reg_write,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state;
  logic [3:0]        in_opcode;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic              hazard;
  logic              xfer_in;
  logic              xfer_out;
  logic              load_entry;

  assign in_opcode = inst[INST_W-1 -: 4];
  assign in_rd     = inst[3*REG_AW-1 -: REG_AW];
  assign in_rs1    = inst[2*REG_AW-1 -: REG_AW];
  assign in_rs2    = inst[REG_AW-1:0];

  // Opcodes 1..11 map directly to bits 0..10. Opcodes 12 and 13 are the
  // immediate forms of add and sub, so they share those bits. Opcodes 14
  // and 15 are the shifts.
  function automatic logic [12:0] dec_alu_op(input logic [3:0] op);
    logic [12:0] v;
    v = 13'd0;
    case (op)
      4'd1:  v[0]  = 1'b1;
      4'd2:  v[1]  = 1'b1;
      4'd3:  v[2]  = 1'b1;
      4'd4:  v[3]  = 1'b1;
      4'd5:  v[4]  = 1'b1;
      4'd6:  v[5]  = 1'b1;
      4'd7:  v[6]  = 1'b1;
      4'd8:  v[7]  = 1'b1;
      4'd9:  v[8]  = 1'b1;
      4'd10: v[9]  = 1'b1;
      4'd11: v[10] = 1'b1;
      4'd12: v[9]  = 1'b1;
      4'd13: v[10] = 1'b1;
      4'd14: v[11] = 1'b1;
      4'd15: v[12] = 1'b1;
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  // Only the two-register ALU opcodes read reg[rs2]. Every other opcode
  // treats the rs2 field as an immediate.
  function automatic logic dec_alu_src(input logic [3:0] op);
    return !((op >= 4'd5) && (op <= 4'd11));
  endfunction

  // nop and Read produce no register result
  function automatic logic dec_reg_write(input logic [3:0] op);
    return (op != 4'd0) && (op != 4'd2);
  endfunction

  // While reset is asserted, the held entry is not offered downstream.
  // This discards it without a handshake.
  assign out_valid  = (state == ST_FULL) && !rst;
  assign in_ready   = !rst && ((state == ST_EMPTY) || out_ready) && !hazard;
  assign xfer_in    = in_valid && in_ready;
  assign xfer_out   = out_valid && out_ready;
  assign load_entry = xfer_in && (in_opcode != 4'd0);

  // Output buffer. A new non-zero entry replaces the held one, including in
  // the cycle the old one leaves. An accepted nop never fills the buffer.
  // In EMPTY the decoded fields read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      alu_op    <= 13'd0;
      alu_src   <= 1'b0;
      reg_write <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
    end else if (load_entry) begin
      state     <= ST_FULL;
      alu_op    <= dec_alu_op(in_opcode);
      alu_src   <= dec_alu_src(in_opcode);
      reg_write <= dec_reg_write(in_opcode);
      rd        <= in_rd;
      rs1       <= in_rs1;
      rs2       <= in_rs2;
    end else if (xfer_out) begin
      state     <= ST_EMPTY;
      alu_op    <= 13'd0;
      alu_src   <= 1'b0;
      reg_write <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
    end
  end

  // Retired counter wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (xfer_out) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef CTRL_PIPE_HAZARD_EN

  logic              pend_valid;
  logic [REG_AW-1:0] pend_rd;
  logic              held_active;
  logic              hit_rs1;
  logic              hit_rs2;

  function automatic logic uses_rs1(input logic [3:0] op);
    return op >= 4'd3;
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd11);
  endfunction

  // The entry that just left is still a pending writer for one more cycle.
  // Its result is not yet visible to a newly decoded instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_rd    <= '0;
    end else begin
      pend_valid <= xfer_out && reg_write;
      pend_rd    <= rd;
    end
  end

  // A source that is used and that matches either pending destination
  // blocks acceptance.
  always_comb begin
    held_active = (state == ST_FULL) && reg_write;
    hit_rs1 = uses_rs1(in_opcode) &&
              ((held_active && (in_rs1 == rd)) || (pend_valid && (in_rs1 == pend_rd)));
    hit_rs2 = uses_rs2(in_opcode) &&
              ((held_active && (in_rs2 == rd)) || (pend_valid && (in_rs2 == pend_rd)));
    hazard  = in_valid && (hit_rs1 || hit_rs2);
  end

  // Stall counter stops at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`else

  assign hazard    = 1'b0;
  assign stall_cnt = '0;

`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe
//
// The bench drives one linear sequence of handshakes and compares the
// outputs against hand-computed values. It instantiates the design with
// CNT_W=4 so that the wrap of retired_cnt and the saturation of stall_cnt
// can be reached in a few cycles. Inputs change 1 time unit after each
// rising edge, and outputs are compared 1 time unit after that.

module tb_ctrl_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] alu_op;
  logic        alu_src;
  logic        reg_write;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  retired_cnt;
  logic [3:0]  stall_cnt;

  int tests_run;
  int fail_cnt;

  ctrl_pipe #(
    .REG_AW(4),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst       (inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the handshake inputs and let combinational outputs settle
  task automatic apply_stimulus(input logic v, input logic [15:0] i, input logic r);
    in_valid  = v;
    inst      = i;
    out_ready = r;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inst      = 16'h0000;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    apply_stimulus(1'b1, 16'hA123, 1'b1);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_retired", retired_cnt, 0);
    check_output("rst_stall", stall_cnt, 0);
    check_output("rst_alu_op", alu_op, 0);
    tick();

    // Register add: accepted in the first cycle after reset
    rst = 1'b0;
    apply_stimulus(1'b1, 16'hA123, 1'b1);
    check_output("first_in_ready", in_ready, 1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("add_out_valid", out_valid, 1);
    check_output("add_alu_op", alu_op, 13'h0200);
    check_output("add_alu_src", alu_src, 0);
    check_output("add_reg_write", reg_write, 1);
    check_output("add_rd", rd, 1);
    check_output("add_rs1", rs1, 2);
    check_output("add_rs2", rs2, 3);
    check_output("add_retired_before", retired_cnt, 0);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("add_drained", out_valid, 0);
    check_output("add_retired", retired_cnt, 1);
    check_output("empty_alu_op", alu_op, 0);
    check_output("empty_rd", rd, 0);

    // Read, followed by a nop that is accepted and dropped
    apply_stimulus(1'b1, 16'h2450, 1'b1);
    tick();
    apply_stimulus(1'b1, 16'h0000, 1'b1);
    check_output("read_out_valid", out_valid, 1);
    check_output("read_alu_op", alu_op, 13'h0002);
    check_output("read_reg_write", reg_write, 0);
    check_output("read_alu_src", alu_src, 1);
    check_output("read_rd", rd, 4);
    check_output("read_rs1", rs1, 5);
    check_output("nop_in_ready", in_ready, 1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("nop_no_valid", out_valid, 0);
    check_output("nop_retired", retired_cnt, 2);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("nop_no_valid_later", out_valid, 0);

    // Backpressure: three offers with out_ready low
    apply_stimulus(1'b1, 16'h3456, 1'b0);
    check_output("bp_first_ready", in_ready, 1);
    tick();
    apply_stimulus(1'b1, 16'h7789, 1'b0);
    check_output("bp_ready_low", in_ready, 0);
    check_output("bp_valid", out_valid, 1);
    check_output("bp_alu_op", alu_op, 13'h0004);
    check_output("bp_rd", rd, 4);
    tick();
    apply_stimulus(1'b1, 16'h7789, 1'b0);
    check_output("bp_hold_alu_op", alu_op, 13'h0004);
    check_output("bp_hold_rs1", rs1, 5);
    check_output("bp_hold_rs2", rs2, 6);
    check_output("bp_ready_still_low", in_ready, 0);
    apply_stimulus(1'b1, 16'h7789, 1'b1);
    check_output("bp_release_ready", in_ready, 1);
    tick();
    apply_stimulus(1'b1, 16'h8ABC, 1'b1);
    check_output("bp_second_alu_op", alu_op, 13'h0040);
    check_output("bp_second_rd", rd, 7);
    check_output("bp_second_src", alu_src, 0);
    check_output("bp_retired_3", retired_cnt, 3);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("bp_third_alu_op", alu_op, 13'h0080);
    check_output("bp_third_rd", rd, 10);
    check_output("bp_retired_4", retired_cnt, 4);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("bp_drained", out_valid, 0);
    check_output("bp_retired_5", retired_cnt, 5);

    // RAW dependency: 0x6432 reads r3 while 0x5312 (writes r3) is held
    apply_stimulus(1'b1, 16'h5312, 1'b0);
    tick();
    apply_stimulus(1'b1, 16'h6432, 1'b0);
    check_output("raw_held_ready", in_ready, 0);
    check_output("raw_held_valid", out_valid, 1);
    check_output("raw_held_alu_op", alu_op, 13'h0010);
    check_output("raw_held_rd", rd, 3);
    tick();
    apply_stimulus(1'b1, 16'h6432, 1'b1);
`ifdef CTRL_PIPE_HAZARD_EN
    check_output("raw_release_ready", in_ready, 0);
    check_output("raw_stall_1", stall_cnt, 1);
    tick();
    apply_stimulus(1'b1, 16'h6432, 1'b1);
    check_output("raw_window_valid", out_valid, 0);
    check_output("raw_window_ready", in_ready, 0);
    check_output("raw_stall_2", stall_cnt, 2);
    check_output("raw_retired_6", retired_cnt, 6);
    tick();
    apply_stimulus(1'b1, 16'h6432, 1'b1);
    check_output("raw_clear_ready", in_ready, 1);
    check_output("raw_stall_3", stall_cnt, 3);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
`else
    check_output("raw_release_ready", in_ready, 1);
    check_output("raw_stall_off", stall_cnt, 0);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("raw_retired_6", retired_cnt, 6);
`endif
    check_output("raw_dep_valid", out_valid, 1);
    check_output("raw_dep_alu_op", alu_op, 13'h0020);
    check_output("raw_dep_rd", rd, 4);
    check_output("raw_dep_rs1", rs1, 3);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("raw_drained", out_valid, 0);
    check_output("raw_retired_7", retired_cnt, 7);

    // Immediate add and right shift
    apply_stimulus(1'b1, 16'hC9F7, 1'b1);
    tick();
    apply_stimulus(1'b1, 16'hF012, 1'b1);
    check_output("addi_alu_op", alu_op, 13'h0200);
    check_output("addi_alu_src", alu_src, 1);
    check_output("addi_rd", rd, 9);
    check_output("addi_rs1", rs1, 15);
    check_output("addi_rs2", rs2, 7);
    check_output("addi_next_ready", in_ready, 1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("rsf_alu_op", alu_op, 13'h1000);
    check_output("rsf_alu_src", alu_src, 1);
    check_output("rsf_reg_write", reg_write, 1);
    check_output("rsf_retired_8", retired_cnt, 8);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("rsf_drained", out_valid, 0);
    check_output("rsf_retired_9", retired_cnt, 9);

    // Long stall against a held writer of r5
    apply_stimulus(1'b1, 16'h1500, 1'b0);
    tick();
    apply_stimulus(1'b1, 16'h3050, 1'b0);
    check_output("sat_ready", in_ready, 0);
    for (int k = 0; k < 14; k++) begin
      tick();
    end
`ifdef CTRL_PIPE_HAZARD_EN
    check_output("sat_stall", stall_cnt, 15);
`else
    check_output("sat_stall_off", stall_cnt, 0);
`endif
    check_output("sat_held_valid", out_valid, 1);
    check_output("sat_held_alu_op", alu_op, 13'h0001);
    check_output("sat_held_rd", rd, 5);

    // Reset while the buffer is full
    rst = 1'b1;
    apply_stimulus(1'b1, 16'h3050, 1'b0);
    check_output("rst_full_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b0, 16'h0000, 1'b0);
    check_output("rst_full_out_valid", out_valid, 0);
    check_output("rst_full_retired", retired_cnt, 0);
    check_output("rst_full_stall", stall_cnt, 0);
    check_output("rst_full_alu_op", alu_op, 0);
    check_output("rst_full_rd", rd, 0);

    // Streaming: 16 handshakes wrap the 4-bit retired counter to zero
    apply_stimulus(1'b1, 16'h1000, 1'b1);
    for (int k = 0; k < 17; k++) begin
      tick();
    end
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("wrap_retired_0", retired_cnt, 0);
    check_output("wrap_valid", out_valid, 1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("wrap_retired_1", retired_cnt, 1);
    check_output("wrap_drained", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
